vecmac_seq: RTL and testbench
=============================

# vecmac_seq

Sequencer for the vector multiply-accumulate datapath. On a start pulse it reads `len` element pairs from two operand memories, with one read issued per cycle. It accumulates the element products into a dot product and presents the result on a valid/ready output handshake. It sits between the operand buffers and the result consumer, and owns all address generation and MAC load/accumulate control.

## Interface
- `N`, 4, maximum vector length (≥2)
- `DW`, 2, element width, unsigned
- Derived: `AW = $clog2(N)`, `LW = $clog2(N)+1`, `RW = 2*DW + $clog2(N)`

- `clk`  in  1  clock, rising edge
- `rst`  in  1  reset rst, asynchronous, active-high
- `start`  in  1  one-cycle request to begin a dot product; honoured only in IDLE
- `len`  in  LW  element count, sampled with `start`
- `rd_en`  out  1  operand memory read strobe
- `rd_addr`  out  AW  element index
- `rd_a`, `rd_b`  in  DW each  operand data; valid the cycle after `rd_en`
- `busy`  out  1  high in any state other than IDLE
- `res_data`  out  RW  dot product
- `res_valid`  out  1  result available
- `res_ready`  in  1  consumer accepts the result

## Operation
- States: IDLE, FETCH, DRAIN, HOLD.
- IDLE → FETCH on `start` with `len` ≥ 1. The block latches `len`, clamped to N when `len` > N. The address counter is cleared.
- IDLE → HOLD on `start` with `len` = 0. `res_data` = 0.
- FETCH:
  - `rd_en`=1 and `rd_addr` = k on the k-th FETCH cycle, counting from 0.
  - After the read of index `len`−1 is issued, the FSM moves to DRAIN.
- Accumulate: in the cycle after each read, the accumulator takes `rd_a*rd_b`.
  - First element loads the product.
  - Later elements add the product to the accumulator.
- DRAIN: one cycle in which the last product is accumulated, then → HOLD.
- HOLD:
  - `res_valid`=1 and `res_data` is held stable.
  - `res_valid && res_ready` → IDLE.
- Arithmetic is unsigned and full width. RW bits cannot overflow because the clamped length is ≤ N.
- `start` is ignored outside IDLE, including in the HOLD handshake cycle.

## Timing
- Reset values: `rd_en`=0, `rd_addr`=0, `busy`=0, `res_valid`=0, `res_data`=0; state IDLE.
- Reset mid-operation discards all progress. No result is produced.
- `start` sampled at edge T0:
  - FETCH occupies cycles 1..L, where L is the clamped length.
  - DRAIN occupies cycle L+1.
  - `res_valid` rises in cycle L+2.
  - Total start-to-valid latency is L+2 cycles.
- `len`=0: `res_valid` rises in cycle 1.
- Throughput: the next `start` is accepted in the cycle after the handshake, so there is at least one IDLE cycle between jobs.
- `res_ready` may be held high in advance. The handshake then completes in the first HOLD cycle.
- All outputs are registered.

## Configuration
- `VECMAC_SEQ_ABORT_EN` defined:
  - Adds input `abort` (1 bit).
  - `abort` in FETCH or DRAIN → IDLE next cycle, with `rd_en`=0 and no `res_valid`.
  - `abort` in HOLD or IDLE has no effect.
  - `abort` has priority over the FETCH/DRAIN transitions.
- Not defined: the port is absent, and every job runs to completion.

## Structure
- Package `vecmac_pkg`:
  - state encoding (IDLE=0, FETCH=1, DRAIN=2, HOLD=3)
  - width helper functions for AW, LW and RW
- Sub-module `vecmac_acc`:
  - registered product accumulator with `load`, `acc_en`, `a`, `b` inputs and `sum` output
  - async reset to 0
- The FSM, address counter and handshake logic live in the top level.

## Test plan
- N=4, DW=2, len=4, a=[1,2,3,3], b=[3,3,2,1] → addresses 0,1,2,3 on consecutive cycles; `res_data`=18; `res_valid` in cycle 6 after `start`.
- len=4 with all operands 3 → `res_data`=36. len=1 with a[0]=2, b[0]=3 → `res_data`=6 in cycle 3.
- len=0 → `res_valid` in cycle 1, `res_data`=0, no `rd_en`. len=7 → clamped to 4 reads.
- `res_ready` held low for 5 cycles → `res_data` stable and `start` pulses ignored; when `res_ready` goes high → IDLE, and the next `start` is accepted.
- `rst` asserted during FETCH index 2 → all outputs 0 immediately. A subsequent job with a=[1,1,1,1], b=[1,1,1,1] returns 4.
- With `VECMAC_SEQ_ABORT_EN`: `abort` in FETCH → no `res_valid` and `busy` drops next cycle. The following job (same vectors as the first scenario) → 18.

Source files
------------

// File: rtl/vecmac_pkg.sv
// Shared state encoding and width helpers for the vector MAC sequencer.
package vecmac_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        HOLD  = 2'd3
    } state_t;

    function automatic int f_aw(input int n);
        return $clog2(n);
    endfunction

    function automatic int f_lw(input int n);
        return $clog2(n) + 1;
    endfunction

    // Wide enough for n full-scale products without overflow.
    function automatic int f_rw(input int n, input int dw);
        return 2 * dw + $clog2(n);
    endfunction

endpackage

// File: rtl/vecmac_acc.sv
// Registered product accumulator: load replaces the sum, acc_en adds to it.
module vecmac_acc
    import vecmac_pkg::*;
#(
    parameter int DW = 2,
    parameter int RW = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic          acc_en,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic [RW-1:0] sum
);

    logic [2*DW-1:0] prod;
    logic [RW-1:0]   prod_ext;

    assign prod     = {{DW{1'b0}}, a} * {{DW{1'b0}}, b};
    assign prod_ext = {{(RW-2*DW){1'b0}}, prod};

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            sum <= '0;
        else if (load)
            sum <= prod_ext;
        else if (acc_en)
            sum <= sum + prod_ext;
    end

endmodule

// File: rtl/vecmac_seq.sv
// Dot-product sequencer: address generation, MAC control and result handshake.
// Optional abort input enabled by defining VECMAC_SEQ_ABORT_EN.
module vecmac_seq
    import vecmac_pkg::*;
#(
    parameter int N  = 4,
    parameter int DW = 2,
    localparam int AW = f_aw(N),
    localparam int LW = f_lw(N),
    localparam int RW = f_rw(N, DW)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [LW-1:0] len,
`ifdef VECMAC_SEQ_ABORT_EN
    input  logic          abort,
`endif
    output logic          rd_en,
    output logic [AW-1:0] rd_addr,
    input  logic [DW-1:0] rd_a,
    input  logic [DW-1:0] rd_b,
    output logic          busy,
    output logic [RW-1:0] res_data,
    output logic          res_valid,
    input  logic          res_ready
);

    state_t        state, state_nxt;
    logic          rd_en_nxt;
    logic [AW-1:0] rd_addr_nxt;
    logic [LW-1:0] len_q, len_nxt;
    logic          zload;
    logic          dv, first;
    logic          abort_req;

`ifdef VECMAC_SEQ_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            rd_en     <= 1'b0;
            rd_addr   <= '0;
            len_q     <= '0;
            busy      <= 1'b0;
            res_valid <= 1'b0;
            dv        <= 1'b0;
            first     <= 1'b0;
        end else begin
            state     <= state_nxt;
            rd_en     <= rd_en_nxt;
            rd_addr   <= rd_addr_nxt;
            len_q     <= len_nxt;
            busy      <= (state_nxt != IDLE);
            res_valid <= (state_nxt == HOLD);
            // Operand data lags the read strobe by one cycle.
            dv        <= rd_en;
            first     <= rd_en && (rd_addr == '0);
        end
    end

    always_comb begin
        state_nxt   = state;
        rd_en_nxt   = 1'b0;
        rd_addr_nxt = rd_addr;
        len_nxt     = len_q;
        zload       = 1'b0;
        unique case (state)
            IDLE: if (start) begin
                if (len == '0) begin
                    state_nxt = HOLD;
                    zload     = 1'b1;
                end else begin
                    state_nxt   = FETCH;
                    len_nxt     = (len > LW'(N)) ? LW'(N) : len;
                    rd_en_nxt   = 1'b1;
                    rd_addr_nxt = '0;
                end
            end
            FETCH: begin
                if ({1'b0, rd_addr} == len_q - LW'(1)) begin
                    state_nxt = DRAIN;
                end else begin
                    rd_en_nxt   = 1'b1;
                    rd_addr_nxt = rd_addr + AW'(1);
                end
            end
            DRAIN: state_nxt = HOLD;
            HOLD:  if (res_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (abort_req && (state == FETCH || state == DRAIN)) begin
            state_nxt   = IDLE;
            rd_en_nxt   = 1'b0;
            rd_addr_nxt = rd_addr;
        end
    end

    // A zero-length job loads a zero product so the result reads 0.
    logic          acc_load, acc_en;
    logic [DW-1:0] acc_a;

    assign acc_load = zload || (dv && first);
    assign acc_en   = dv && !first && !zload;
    assign acc_a    = zload ? '0 : rd_a;

    vecmac_acc #(.DW(DW), .RW(RW)) u_acc (
        .clk    (clk),
        .rst    (rst),
        .load   (acc_load),
        .acc_en (acc_en),
        .a      (acc_a),
        .b      (rd_b),
        .sum    (res_data)
    );

endmodule

// File: tb/tb_vecmac_seq.sv
// Directed bench for vecmac_seq with a registered-read operand memory model.
module tb_vecmac_seq;
    localparam int N = 4, DW = 2, AW = 2, LW = 3, RW = 6;

    logic          clk = 1'b0;
    logic          rst, start, res_ready;
    logic [LW-1:0] len;
    logic          rd_en, busy, res_valid;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_a, rd_b;
    logic [RW-1:0] res_data;
`ifdef VECMAC_SEQ_ABORT_EN
    logic          abort;
`endif

    logic [DW-1:0] mem_a [N];
    logic [DW-1:0] mem_b [N];
    int nchk = 0, nerr = 0;

    vecmac_seq #(.N(N), .DW(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .len       (len),
`ifdef VECMAC_SEQ_ABORT_EN
        .abort     (abort),
`endif
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_a      (rd_a),
        .rd_b      (rd_b),
        .busy      (busy),
        .res_data  (res_data),
        .res_valid (res_valid),
        .res_ready (res_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rd_en) begin
            rd_a <= mem_a[rd_addr];
            rd_b <= mem_b[rd_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic set_mem(input int a0, a1, a2, a3, b0, b1, b2, b3);
        mem_a[0] = DW'(a0); mem_a[1] = DW'(a1); mem_a[2] = DW'(a2); mem_a[3] = DW'(a3);
        mem_b[0] = DW'(b0); mem_b[1] = DW'(b1); mem_b[2] = DW'(b2); mem_b[3] = DW'(b3);
    endtask

    // Called at a negedge; returns at the negedge of cycle 1 after start.
    task automatic launch(input int l);
        start = 1'b1;
        len   = LW'(l);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_res(input string tag, input int exp_data, input int exp_lat, input int exp_reads);
        int c, reads;
        c = 1;
        reads = 0;
        while (!res_valid && c <= 20) begin
            if (rd_en) begin
                chk({tag, "_addr"}, 32'(rd_addr), 32'(reads));
                reads++;
            end
            @(negedge clk);
            c++;
        end
        chk({tag, "_lat"}, res_valid ? 32'(c) : 32'd0, 32'(exp_lat));
        chk({tag, "_data"}, 32'(res_data), 32'(exp_data));
        chk({tag, "_reads"}, 32'(reads), 32'(exp_reads));
        if (res_ready) begin
            @(negedge clk);
            chk({tag, "_idle"}, {31'd0, busy | res_valid}, 32'd0);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; len = '0; res_ready = 1'b1;
        rd_a = '0; rd_b = '0;
`ifdef VECMAC_SEQ_ABORT_EN
        abort = 1'b0;
`endif
        set_mem(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("rst_rd_en", {31'd0, rd_en}, 0);
        chk("rst_rd_addr", 32'(rd_addr), 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_valid", {31'd0, res_valid}, 0);
        chk("rst_data", 32'(res_data), 0);
        rst = 1'b0;
        @(negedge clk);

        set_mem(1, 2, 3, 3, 3, 3, 2, 1);
        launch(4);
        wait_res("job18", 18, 6, 4);

        set_mem(3, 3, 3, 3, 3, 3, 3, 3);
        launch(4);
        wait_res("job36", 36, 6, 4);

        set_mem(2, 0, 0, 0, 3, 0, 0, 0);
        launch(1);
        wait_res("len1", 6, 3, 1);

        launch(0);
        wait_res("len0", 0, 1, 0);

        set_mem(1, 1, 1, 1, 2, 2, 2, 2);
        launch(7);
        wait_res("clamp", 8, 6, 4);

        // Consumer stalls: result must hold and start must be ignored.
        res_ready = 1'b0;
        set_mem(3, 2, 0, 0, 1, 3, 0, 0);
        launch(2);
        wait_res("bp", 9, 4, 2);
        for (int i = 0; i < 5; i++) begin
            start = 1'b1;
            len   = LW'(4);
            @(negedge clk);
            chk("bp_valid", {31'd0, res_valid}, 1);
            chk("bp_data", 32'(res_data), 9);
            chk("bp_rd_en", {31'd0, rd_en}, 0);
        end
        res_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("bp_hs_busy", {31'd0, busy}, 0);
        chk("bp_hs_valid", {31'd0, res_valid}, 0);
        chk("bp_hs_rd_en", {31'd0, rd_en}, 0);
        set_mem(1, 2, 3, 3, 3, 3, 2, 1);
        launch(4);
        wait_res("bp_next", 18, 6, 4);

        // Reset while fetching index 2.
        set_mem(1, 1, 1, 1, 1, 1, 1, 1);
        launch(4);
        @(negedge clk);
        @(negedge clk);
        chk("mid_addr", 32'(rd_addr), 2);
        rst = 1'b1;
        #1;
        chk("mid_rst_rd_en", {31'd0, rd_en}, 0);
        chk("mid_rst_addr", 32'(rd_addr), 0);
        chk("mid_rst_busy", {31'd0, busy}, 0);
        chk("mid_rst_valid", {31'd0, res_valid}, 0);
        chk("mid_rst_data", 32'(res_data), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        launch(4);
        wait_res("post_rst", 4, 6, 4);

`ifdef VECMAC_SEQ_ABORT_EN
        begin
            logic seen;
            set_mem(1, 2, 3, 3, 3, 3, 2, 1);
            launch(4);
            @(negedge clk);
            abort = 1'b1;
            @(negedge clk);
            abort = 1'b0;
            chk("abort_busy", {31'd0, busy}, 0);
            chk("abort_rd_en", {31'd0, rd_en}, 0);
            seen = 1'b0;
            for (int i = 0; i < 8; i++) begin
                seen = seen | res_valid;
                @(negedge clk);
            end
            chk("abort_no_valid", {31'd0, seen}, 0);
            launch(4);
            wait_res("post_abort", 18, 6, 4);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
